// File: rtl/vu_vt_fetch.sv
// vu_vt_fetch: vector-thread instruction fetch sequencer.
//
// On vt_fire the block captures vt_pc and streams word fetches to the
// instruction memory. Responses land in a small circular buffer that feeds VT
// decode/issue. The number of fetches in flight plus the number of buffered
// entries never exceeds DEPTH, so the buffer cannot overflow and the memory
// needs no backpressure. Once the stop instruction reaches the head of the
// buffer and every in-flight fetch has returned, vt_stop pulses for one cycle,
// the buffer is flushed and the block returns to idle.
//
// Ports
//   clk            : sole clock, all state updates on posedge
//   reset          : synchronous, active-low reset
//   vt_fire        : start pulse from TVEC (ignored unless idle)
//   vt_pc          : start PC, sampled with vt_fire
//   vt_stop        : one-cycle pulse, thread block complete
//   imem_req_val   : fetch request valid
//   imem_req_rdy   : memory accepts the request
//   imem_req_addr  : fetch byte address
//   imem_resp_val  : fetch response valid (in order, no backpressure)
//   imem_resp_data : fetched instruction
//   inst_val       : head instruction valid to VT issue
//   inst_rdy       : VT issue accepts the head instruction
//   inst_bits      : head instruction bits
//   inst_pc        : PC of the head instruction

module vu_vt_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [6:0]  STOP_OPC = 7'b1110111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vt_fire,
  input  logic [31:0] vt_pc,
  output logic        vt_stop,
  output logic        imem_req_val,
  input  logic        imem_req_rdy,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_val,
  input  logic [31:0] imem_resp_data,
  output logic        inst_val,
  input  logic        inst_rdy,
  output logic [31:0] inst_bits,
  output logic [31:0] inst_pc
);

  localparam int unsigned     PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW      = $clog2(DEPTH + 1);
  localparam logic [CntW:0]   CreditMax = (CntW + 1)'(DEPTH);
  localparam logic [PtrW-1:0] PtrLast   = PtrW'(DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } state_e;

  state_e            state_q;
  logic [31:0]       fetch_pc_q;
  logic [31:0]       resp_pc_q;
  logic [CntW-1:0]   outstanding_q;
  logic [CntW-1:0]   count_q;
  logic [PtrW-1:0]   head_q;
  logic [PtrW-1:0]   tail_q;
  logic [31:0]       buf_bits_q [DEPTH];
  logic [31:0]       buf_pc_q   [DEPTH];
  logic              buf_stop_q [DEPTH];

  logic [CntW:0]     credits_used;
  logic              req_fire;
  logic              resp_take;
  logic              resp_is_stop;
  logic              enq;
  logic              buf_nonempty;
  logic              head_is_stop;
  logic              pop;
  logic [CntW-1:0]   outstanding_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // Every fetch either sits in flight or occupies a buffer slot; a request is
  // only issued while a slot is guaranteed for its response.
  assign credits_used  = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_val  = (state_q == StFetch) && (credits_used < CreditMax);
  assign imem_req_addr = fetch_pc_q;
  assign req_fire      = imem_req_val & imem_req_rdy;

  // A response with nothing outstanding is stray (e.g. after a reset) and dropped.
  assign resp_take     = imem_resp_val && (outstanding_q != '0);
  assign resp_is_stop  = (imem_resp_data[6:0] == STOP_OPC);
  assign enq           = resp_take && (state_q == StFetch);

  assign buf_nonempty  = (count_q != '0);
  assign head_is_stop  = buf_nonempty && buf_stop_q[head_q];
  assign inst_val      = buf_nonempty && !buf_stop_q[head_q];
  assign inst_bits     = buf_bits_q[head_q];
  assign inst_pc       = buf_pc_q[head_q];
  assign pop           = inst_val && inst_rdy;

  assign outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(resp_take);

  // Completion counts a response returning in this same cycle. No request can
  // fire here: a stop at the head implies the block is draining.
  assign vt_stop       = head_is_stop && (outstanding_d == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      fetch_pc_q    <= '0;
      resp_pc_q     <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_bits_q[i] <= '0;
        buf_pc_q[i]   <= '0;
        buf_stop_q[i] <= 1'b0;
      end
    end else begin
      outstanding_q <= outstanding_d;

      if (req_fire) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end

      if (enq) begin
        buf_bits_q[tail_q] <= imem_resp_data;
        buf_pc_q[tail_q]   <= resp_pc_q;
        buf_stop_q[tail_q] <= resp_is_stop;
        tail_q             <= ptr_inc(tail_q);
        resp_pc_q          <= resp_pc_q + 32'd4;
      end

      if (pop) begin
        head_q <= ptr_inc(head_q);
      end

      unique case (state_q)
        StIdle: begin
          if (vt_fire) begin
            state_q    <= StFetch;
            fetch_pc_q <= vt_pc;
            resp_pc_q  <= vt_pc;
          end
        end
        StFetch: begin
          // Requests accepted this cycle stay counted in outstanding_q and
          // are drained and discarded later.
          if (enq && resp_is_stop) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (vt_stop) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Completion pops the stop entry and flushes the whole buffer.
      if (vt_stop) begin
        count_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
      end else begin
        count_q <= count_q + CntW'(enq) - CntW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_vu_vt_fetch.sv
module tb_vu_vt_fetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [6:0]  STOP  = 7'b1110111;

  logic        clk = 1'b0;
  logic        reset;
  logic        vt_fire;
  logic [31:0] vt_pc;
  logic        vt_stop;
  logic        imem_req_val;
  logic        imem_req_rdy;
  logic [31:0] imem_req_addr;
  logic        imem_resp_val;
  logic [31:0] imem_resp_data;
  logic        inst_val;
  logic        inst_rdy;
  logic [31:0] inst_bits;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  vu_vt_fetch #(
    .DEPTH    (DEPTH),
    .STOP_OPC (STOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .vt_fire        (vt_fire),
    .vt_pc          (vt_pc),
    .vt_stop        (vt_stop),
    .imem_req_val   (imem_req_val),
    .imem_req_rdy   (imem_req_rdy),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_val  (imem_resp_val),
    .imem_resp_data (imem_resp_data),
    .inst_val       (inst_val),
    .inst_rdy       (inst_rdy),
    .inst_bits      (inst_bits),
    .inst_pc        (inst_pc)
  );

  typedef struct packed {
    int          due;
    logic [31:0] addr;
  } pend_t;

  typedef struct packed {
    logic [31:0] bits;
    logic [31:0] pc;
  } inst_t;

  int vectors     = 0;
  int miscompares = 0;

  // Environment knobs.
  int          cyc       = 0;
  int          lat       = 1;
  int          rdy_pct   = 100;
  int          irdy_pct  = 100;
  int          spur_pct  = 0;
  logic [31:0] stop_addr = 32'h0;

  // Memory model: fetches in flight with the cycle their response is due.
  pend_t pend[$];

  // Reference model of the block: what the issue side should see.
  inst_t       exp_q[$];
  bit          m_active    = 1'b0;
  bit          m_stopped   = 1'b0;
  int          m_inflight  = 0;
  logic [31:0] m_next_addr = 32'h0;
  logic [31:0] m_resp_pc   = 32'h0;

  // Logs of what the DUT actually did.
  logic [31:0] req_log[$];
  logic [31:0] pc_log[$];
  int          dut_stops   = 0;
  int          model_stops = 0;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == stop_addr) return {a[27:3], STOP};
    return {a[24:0] ^ 25'h1a5a5a5, 7'b0110011};
  endfunction

  // One clock: drive inputs at the falling edge, compare shortly after, then
  // advance the model by what happens at the next rising edge.
  task automatic cycle(input bit fire, input logic [31:0] fpc, input bit rst);
    bit          resp_v;
    bit          resp_acc;
    bit          exp_rv;
    bit          exp_iv;
    bit          exp_stop;
    bit          act0;
    logic [31:0] resp_d;
    @(negedge clk);
    reset        = ~rst;
    vt_fire      = fire;
    vt_pc        = fpc;
    imem_req_rdy = !rst && (int'($urandom_range(99)) < rdy_pct);
    inst_rdy     = (int'($urandom_range(99)) < irdy_pct);
    resp_v       = 1'b0;
    resp_d       = $urandom();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      resp_v = 1'b1;
      resp_d = instr_at(pend[0].addr);
      pend.delete(0);
    end else if (m_inflight == 0 && int'($urandom_range(99)) < spur_pct) begin
      resp_v = 1'b1;
    end
    imem_resp_val  = resp_v;
    imem_resp_data = resp_d;
    #1;
    act0     = m_active;
    exp_rv   = m_active && !m_stopped && ((m_inflight + exp_q.size()) < int'(DEPTH));
    exp_iv   = (exp_q.size() > 0);
    resp_acc = resp_v && (m_inflight > 0);
    exp_stop = m_stopped && (exp_q.size() == 0) && ((m_inflight - int'(resp_acc)) == 0);

    vectors++;
    if (vt_stop !== exp_stop) begin
      miscompares++;
      $display("FAIL vt_stop cyc %0d: got %b want %b", cyc, vt_stop, exp_stop);
    end
    vectors++;
    if (imem_req_val !== exp_rv) begin
      miscompares++;
      $display("FAIL imem_req_val cyc %0d: got %b want %b", cyc, imem_req_val, exp_rv);
    end
    if (exp_rv) begin
      vectors++;
      if (imem_req_addr !== m_next_addr) begin
        miscompares++;
        $display("FAIL imem_req_addr cyc %0d: got %h want %h", cyc, imem_req_addr, m_next_addr);
      end
    end
    vectors++;
    if (inst_val !== exp_iv) begin
      miscompares++;
      $display("FAIL inst_val cyc %0d: got %b want %b", cyc, inst_val, exp_iv);
    end
    if (exp_iv) begin
      vectors++;
      if (inst_bits !== exp_q[0].bits || inst_pc !== exp_q[0].pc) begin
        miscompares++;
        $display("FAIL inst_head cyc %0d: got %h/%h want %h/%h", cyc, inst_bits, inst_pc,
                 exp_q[0].bits, exp_q[0].pc);
      end
    end

    if (imem_req_val === 1'b1 && imem_req_rdy) req_log.push_back(imem_req_addr);
    if (inst_val === 1'b1 && inst_rdy) pc_log.push_back(inst_pc);
    if (vt_stop === 1'b1) dut_stops++;

    if (rst) begin
      m_active   = 1'b0;
      m_stopped  = 1'b0;
      m_inflight = 0;
      exp_q.delete();
    end else begin
      if (exp_iv && inst_rdy) exp_q.delete(0);
      if (resp_acc) begin
        m_inflight--;
        if (m_active && !m_stopped) begin
          if (resp_d[6:0] == STOP) m_stopped = 1'b1;
          else exp_q.push_back('{bits: resp_d, pc: m_resp_pc});
          m_resp_pc += 32'd4;
        end
      end
      if (exp_rv && imem_req_rdy) begin
        pend.push_back('{due: cyc + lat, addr: m_next_addr});
        m_inflight++;
        m_next_addr += 32'd4;
      end
      if (exp_stop) begin
        m_active  = 1'b0;
        m_stopped = 1'b0;
        model_stops++;
      end
      if (fire && !act0) begin
        m_active    = 1'b1;
        m_next_addr = fpc;
        m_resp_pc   = fpc;
      end
    end
    cyc++;
  endtask

  task automatic run_until_stop(input int budget);
    int s0;
    int n;
    s0 = model_stops;
    n  = 0;
    while (model_stops == s0 && n < budget) begin
      cycle(1'b0, 32'h0, 1'b0);
      n++;
    end
    vectors++;
    if (model_stops == s0) begin
      miscompares++;
      $display("FAIL stop_timeout: got no completion in %0d cycles, want one", budget);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (vt_stop !== 1'b0 || imem_req_val !== 1'b0 || inst_val !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got stop=%b req=%b iv=%b want 0/0/0", vt_stop, imem_req_val,
               inst_val);
    end
    vectors++;
    if (imem_req_addr !== 32'h0 || inst_bits !== 32'h0 || inst_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%h/%h want 0/0/0", imem_req_addr, inst_bits, inst_pc);
    end
  endtask

  task automatic test_basic;
    int l0;
    int p0;
    int d0;
    lat = 1; rdy_pct = 100; irdy_pct = 100; spur_pct = 0;
    stop_addr = 32'h100C;
    l0 = req_log.size(); p0 = pc_log.size(); d0 = dut_stops;
    cycle(1'b1, 32'h1000, 1'b0);
    run_until_stop(50);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (req_log.size() <= l0 + i || req_log[l0 + i] !== 32'h1000 + 32'(4 * i)) begin
        miscompares++;
        $display("FAIL basic_req%0d: got %0d reqs, want addr %h", i, req_log.size() - l0,
                 32'h1000 + 32'(4 * i));
      end
    end
    vectors++;
    if (pc_log.size() - p0 != 3) begin
      miscompares++;
      $display("FAIL basic_count: got %0d insts want 3", pc_log.size() - p0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (pc_log[p0 + i] !== 32'h1000 + 32'(4 * i)) begin
          miscompares++;
          $display("FAIL basic_pc%0d: got %h want %h", i, pc_log[p0 + i], 32'h1000 + 32'(4 * i));
        end
      end
    end
    vectors++;
    if (dut_stops - d0 != 1) begin
      miscompares++;
      $display("FAIL basic_stops: got %0d want 1", dut_stops - d0);
    end
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_backpressure;
    int l0;
    int p0;
    lat = 2; rdy_pct = 100; irdy_pct = 0; spur_pct = 0;
    stop_addr = 32'h4020;
    l0 = req_log.size(); p0 = pc_log.size();
    cycle(1'b1, 32'h4000, 1'b0);
    repeat (15) cycle(1'b0, 32'h0, 1'b0);
    vectors++;
    if (req_log.size() - l0 != int'(DEPTH)) begin
      miscompares++;
      $display("FAIL bp_accepted: got %0d want %0d", req_log.size() - l0, DEPTH);
    end
    vectors++;
    if (imem_req_val !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_req_val: got %b want 0", imem_req_val);
    end
    irdy_pct = 60;
    run_until_stop(300);
    vectors++;
    if (pc_log.size() - p0 != 8) begin
      miscompares++;
      $display("FAIL bp_count: got %0d insts want 8", pc_log.size() - p0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (pc_log[p0 + i] !== 32'h4000 + 32'(4 * i)) begin
          miscompares++;
          $display("FAIL bp_pc%0d: got %h want %h", i, pc_log[p0 + i], 32'h4000 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_post_stop_discard;
    int l0;
    int p0;
    int d0;
    lat = 4; rdy_pct = 100; irdy_pct = 100; spur_pct = 0;
    stop_addr = 32'h2008;
    l0 = req_log.size(); p0 = pc_log.size(); d0 = dut_stops;
    cycle(1'b1, 32'h2000, 1'b0);
    run_until_stop(100);
    vectors++;
    if (req_log.size() - l0 != 5 || req_log[req_log.size() - 1] !== 32'h2010) begin
      miscompares++;
      $display("FAIL discard_reqs: got %0d reqs want 5 ending at 2010", req_log.size() - l0);
    end
    vectors++;
    if (pc_log.size() - p0 != 2 || pc_log[pc_log.size() - 1] !== 32'h2004) begin
      miscompares++;
      $display("FAIL discard_insts: got %0d insts want 2 ending at 2004", pc_log.size() - p0);
    end
    vectors++;
    if (dut_stops - d0 != 1) begin
      miscompares++;
      $display("FAIL discard_stops: got %0d want 1", dut_stops - d0);
    end
  endtask

  task automatic test_wrap;
    int l0;
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    lat = 1; rdy_pct = 100; irdy_pct = 100; spur_pct = 0;
    stop_addr = 32'h0000_0004;
    l0 = req_log.size();
    cycle(1'b1, 32'hFFFF_FFF8, 1'b0);
    run_until_stop(50);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (req_log.size() <= l0 + i || req_log[l0 + i] !== want[i]) begin
        miscompares++;
        $display("FAIL wrap_req%0d: got %0d reqs, want addr %h", i, req_log.size() - l0, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_fetch;
    int n;
    int p0;
    int d0;
    lat = 4; rdy_pct = 100; irdy_pct = 100; spur_pct = 0;
    stop_addr = 32'h7040;
    cycle(1'b1, 32'h7000, 1'b0);
    n = 0;
    while (m_inflight < 3 && n < 20) begin
      cycle(1'b0, 32'h0, 1'b0);
      n++;
    end
    cycle(1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    vectors++;
    if (vt_stop !== 1'b0 || imem_req_val !== 1'b0 || inst_val !== 1'b0 ||
        imem_req_addr !== 32'h0 || inst_bits !== 32'h0 || inst_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_outs: got %b%b%b %h %h %h want all zero", vt_stop, imem_req_val,
               inst_val, imem_req_addr, inst_bits, inst_pc);
    end
    p0 = pc_log.size();
    spur_pct = 30;
    n = 0;
    while ((pend.size() > 0 || n < 5) && n < 40) begin
      cycle(1'b0, 32'h0, 1'b0);
      n++;
    end
    vectors++;
    if (pc_log.size() != p0) begin
      miscompares++;
      $display("FAIL midreset_late: got %0d insts want 0", pc_log.size() - p0);
    end
    spur_pct = 0;
    stop_addr = 32'h3010;
    p0 = pc_log.size(); d0 = dut_stops;
    cycle(1'b1, 32'h3000, 1'b0);
    run_until_stop(100);
    vectors++;
    if (pc_log.size() - p0 != 4 || pc_log[p0] !== 32'h3000) begin
      miscompares++;
      $display("FAIL midreset_restart: got %0d insts want 4 from 3000", pc_log.size() - p0);
    end
    vectors++;
    if (dut_stops - d0 != 1) begin
      miscompares++;
      $display("FAIL midreset_stops: got %0d want 1", dut_stops - d0);
    end
  endtask

  task automatic test_illegal_fire;
    int l0;
    lat = 2; rdy_pct = 70; irdy_pct = 80; spur_pct = 0;
    stop_addr = 32'h6018;
    l0 = req_log.size();
    cycle(1'b1, 32'h6000, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h5000, 1'b0);
    run_until_stop(200);
    for (int i = 0; i < req_log.size() - l0; i++) begin
      vectors++;
      if (req_log[l0 + i] !== 32'h6000 + 32'(4 * i)) begin
        miscompares++;
        $display("FAIL illegal_fire_req%0d: got %h want %h", i, req_log[l0 + i],
                 32'h6000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_back_to_back;
    int l0;
    int p0;
    lat = 1; rdy_pct = 100; irdy_pct = 100; spur_pct = 0;
    stop_addr = 32'h8008;
    cycle(1'b1, 32'h8000, 1'b0);
    run_until_stop(50);
    // Fire again in the first idle cycle after completion.
    stop_addr = 32'h9004;
    l0 = req_log.size(); p0 = pc_log.size();
    cycle(1'b1, 32'h9000, 1'b0);
    run_until_stop(50);
    vectors++;
    if (req_log.size() == l0 || req_log[l0] !== 32'h9000) begin
      miscompares++;
      $display("FAIL b2b_first_req: got %0d reqs, want first addr 9000", req_log.size() - l0);
    end
    vectors++;
    if (pc_log.size() - p0 != 1) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d insts want 1", pc_log.size() - p0);
    end
  endtask

  task automatic test_random;
    logic [31:0] pc;
    int          len;
    int          p0;
    for (int b = 0; b < 8; b++) begin
      pc        = $urandom() & 32'hFFFF_FFFC;
      len       = int'($urandom_range(9, 1));
      stop_addr = pc + 32'(4 * len);
      lat       = int'($urandom_range(3, 1));
      rdy_pct   = int'($urandom_range(100, 40));
      irdy_pct  = int'($urandom_range(100, 40));
      spur_pct  = 20;
      p0        = pc_log.size();
      cycle(1'b1, pc, 1'b0);
      run_until_stop(500);
      vectors++;
      if (pc_log.size() - p0 != len) begin
        miscompares++;
        $display("FAIL rand%0d_count: got %0d insts want %0d", b, pc_log.size() - p0, len);
      end
      repeat (int'($urandom_range(3, 0))) cycle(1'b0, 32'h0, 1'b0);
    end
    spur_pct = 0;
  endtask

  initial begin
    reset          = 1'b0;
    vt_fire        = 1'b0;
    vt_pc          = 32'h0;
    imem_req_rdy   = 1'b0;
    imem_resp_val  = 1'b0;
    imem_resp_data = 32'h0;
    inst_rdy       = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_post_stop_discard();
    test_wrap();
    test_reset_mid_fetch();
    test_illegal_fire();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
